// File: rtl/osd_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM between PORT_NUM character overlays.
// Defining OSD_ARB_CONFLICT_CNT_EN adds a saturating contention-cycle counter.
module osd_rom_arbiter #(
  parameter int PORT_NUM = 10,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [PORT_NUM-1:0]          i_req,
  input  logic [PORT_NUM*ADDR_W-1:0]   i_rd_addr,
  output logic [PORT_NUM-1:0]          o_gnt,
  output logic                         o_rom_en,
  output logic [ADDR_W-1:0]            o_rom_addr,
  input  logic [DATA_W-1:0]            i_rom_data,
  output logic [PORT_NUM-1:0]          o_rd_vld,
  output logic [PORT_NUM*DATA_W-1:0]   o_rd_data,
  output logic [15:0]                  o_conflict_cnt
);

  localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic                       gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0]           gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [ADDR_W-1:0]          rom_addr_q, rom_addr_d;
  logic                       tag_vld_q [ROM_LAT];
  logic                       tag_vld_d [ROM_LAT];
  logic [IDX_W-1:0]           tag_idx_q [ROM_LAT];
  logic [IDX_W-1:0]           tag_idx_d [ROM_LAT];
  logic [PORT_NUM*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [PORT_NUM-1:0]        gnt_oh;
  logic [PORT_NUM-1:0]        rd_vld_oh;
  logic [PORT_NUM-1:0]        req_masked;

  always_comb begin : decode
    gnt_oh    = '0;
    rd_vld_oh = '0;
    if (gnt_vld_q) gnt_oh[gnt_idx_q] = 1'b1;
    if (tag_vld_q[ROM_LAT-1]) rd_vld_oh[tag_idx_q[ROM_LAT-1]] = 1'b1;
  end

  // Scan offsets from far to near so the nearest requester at or above ptr wins.
  always_comb begin : arbitrate
    int cand;
    cand       = 0;
    gnt_vld_d  = 1'b0;
    gnt_idx_d  = '0;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    req_masked = i_req & ~gnt_oh;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      cand = int'(ptr_q) + i;
      if (cand >= PORT_NUM) cand = cand - PORT_NUM;
      if (req_masked[cand]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = IDX_W'(cand);
      end
    end
    if (gnt_vld_d) begin
      rom_addr_d = i_rd_addr[gnt_idx_d*ADDR_W +: ADDR_W];
      ptr_d      = (int'(gnt_idx_d) == PORT_NUM - 1) ? '0 : gnt_idx_d + 1'b1;
    end
  end

  always_comb begin : tag_pipe
    tag_vld_d[0] = gnt_vld_q;
    tag_idx_d[0] = gnt_idx_q;
    for (int s = 1; s < ROM_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // The returning slice follows the ROM bus in its strobe cycle, then holds.
  always_comb begin : rd_capture
    rd_data_d = rd_data_q;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (rd_vld_oh[k]) rd_data_d[k*DATA_W +: DATA_W] = i_rom_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_idx_q[s] <= '0;
      end
    end else begin
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_d[s];
        tag_idx_q[s] <= tag_idx_d[s];
      end
    end
  end

`ifdef OSD_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Two or more bits set is detected by clearing the lowest set bit.
  always_comb begin : conflict_count
    conflict_cnt_d = conflict_cnt_q;
    if (((i_req & (i_req - PORT_NUM'(1))) != '0) && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) conflict_cnt_q <= '0;
    else          conflict_cnt_q <= conflict_cnt_d;
  end

  assign o_conflict_cnt = conflict_cnt_q;
`else
  assign o_conflict_cnt = 16'd0;
`endif

  assign o_gnt      = gnt_oh;
  assign o_rom_en   = gnt_vld_q;
  assign o_rom_addr = rom_addr_q;
  assign o_rd_vld   = rd_vld_oh;
  assign o_rd_data  = rd_data_d;

endmodule

// File: doc/osd_rom_arbiter.md
OSD_ROM_ARBITER -- requirements
Module: osd_rom_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 10, number of requesting character overlays (2..16).
REQ-002 SHALL have parameter ADDR_W, default 13, font ROM address width.
REQ-003 SHALL have parameter DATA_W, default 16, font ROM word width.
REQ-004 SHALL have parameter ROM_LAT, default 1, font ROM read latency in cycles (1..3).
REQ-005 SHALL have port i_clk  input  1  pixel clock; the single clock of the block.
REQ-006 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_req  input  PORT_NUM  per-port read request, level, held until granted.
REQ-008 SHALL have port i_rd_addr  input  PORT_NUM*ADDR_W  per-port address; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port o_gnt  output  PORT_NUM  one-hot grant, one cycle wide.
REQ-010 SHALL have port o_rom_en  output  1  ROM read enable.
REQ-011 SHALL have port o_rom_addr  output  ADDR_W  ROM address.
REQ-012 SHALL have port i_rom_data  input  DATA_W  ROM data, valid ROM_LAT cycles after o_rom_en.
REQ-013 SHALL have port o_rd_vld  output  PORT_NUM  one-hot return strobe, one cycle wide.
REQ-014 SHALL have port o_rd_data  output  PORT_NUM*DATA_W  per-port returned word, same slicing as i_rd_addr.
REQ-015 SHALL have port o_conflict_cnt  output  16  count of contention cycles (see Configuration).

Function
REQ-016 SHALL issue at most one grant per cycle; o_gnt is zero when i_req is zero.
REQ-017 SHALL choose the winner round-robin: first requesting port at or above pointer ptr, wrapping from PORT_NUM-1 to 0.
REQ-018 SHALL advance ptr to (winner+1) mod PORT_NUM in the cycle after a grant; ptr holds when no grant.
REQ-019 SHALL register o_gnt, o_rom_en, o_rom_addr: for a request sampled at edge N these are asserted after edge N (grant latency 1 cycle), o_rom_addr = winner's i_rd_addr sampled at N.
REQ-020 SHALL mask a port's i_req during the cycle its o_gnt is high so a held request is not granted twice for one read.
REQ-021 SHALL carry the winner index through a ROM_LAT-deep tag pipeline and assert o_rd_vld[tag] exactly ROM_LAT cycles after o_gnt, capturing i_rom_data into that port's o_rd_data slice.
REQ-022 SHALL hold each o_rd_data slice unchanged until that port's next o_rd_vld.
REQ-023 SHALL sustain one grant per cycle under continuous requests (full throughput, reads pipelined).
REQ-024 SHALL treat a request deasserted before grant as withdrawn, with no ROM access and no o_rd_vld.
REQ-025 SHALL ignore i_rd_addr changes on non-granted ports.

Reset
REQ-026 SHALL, on i_rst_n low at an i_clk edge, clear o_gnt, o_rom_en, o_rd_vld, o_rom_addr, all o_rd_data slices, o_conflict_cnt, the tag pipeline, and set ptr to 0.
REQ-027 SHALL discard in-flight reads at reset: no o_rd_vld for any read granted before reset.
REQ-028 SHALL accept requests on the first edge with i_rst_n high.

Configuration
REQ-029 SHALL use macro OSD_ARB_CONFLICT_CNT_EN: when defined, o_conflict_cnt increments by 1 each cycle with two or more i_req bits high, saturating at 16'hFFFF.
REQ-030 SHALL, when OSD_ARB_CONFLICT_CNT_EN is undefined, drive o_conflict_cnt constant 0 with no counter logic.

Verification
REQ-031 SHALL cover: single port 3 requests addr 13'h0041, ROM_LAT=1 -> o_gnt=0x008 one cycle, o_rom_addr=0x0041, o_rd_vld=0x008 next cycle, slice 3 = ROM[0x41].
REQ-032 SHALL cover: all 10 ports held high from reset, ptr=0 -> grants 0,1,...,9,0 in consecutive cycles, each port gets exactly one o_rd_vld per 10 cycles.
REQ-033 SHALL cover: ports 9 and 0 request, ptr=9 -> port 9 granted first, port 0 next cycle (wrap-around).
REQ-034 SHALL cover: ROM_LAT=3, grants to ports 2,5,7 back-to-back -> o_rd_vld 0x004,0x020,0x080 three cycles after each grant with correct data.
REQ-035 SHALL cover: reset asserted one cycle after grant with ROM_LAT=2 -> no o_rd_vld, all outputs 0, ptr=0 on release.
REQ-036 SHALL cover: macro defined, ports 1 and 4 high for 5 cycles -> o_conflict_cnt=5; macro undefined -> stays 0.
